// File: rtl/clock_time_ctrl_if.sv
// Bundle between the clock time controller and its neighbours: the 1 s tick
// source, the debounced buttons and the 4-digit display mux.
// Signalling: tick1s is a one-sysclk-wide enable pulse. btnMode and btnInc
// are levels synchronous to sysclk. A rising edge of a button level is one
// request. The controller has no ready/backpressure and accepts every request
// on the edge it is sampled. All display outputs are levels that update after
// a rising sysclk edge, or immediately on reset.
interface clock_time_ctrl_if;
  logic       tick1s;
  logic       btnMode;
  logic       btnInc;
  logic [3:0] hTens;
  logic [3:0] hOnes;
  logic [3:0] mTens;
  logic [3:0] mOnes;
  logic [3:0] blank;
  logic [1:0] mode;
  logic       pm;

  // Driver side: tick source, buttons, display consumer.
  modport master (
    output tick1s, btnMode, btnInc,
    input  hTens, hOnes, mTens, mOnes, blank, mode, pm
  );

  // Controller side.
  modport slave (
    input  tick1s, btnMode, btnInc,
    output hTens, hOnes, mTens, mOnes, blank, mode, pm
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Time-keeping and set-mode controller for a 4-digit 7-segment clock.
// Keeps 24-hour time as BCD digits and advances it on the 1 s tick.
// btnMode cycles through RUN -> SET_HOUR -> SET_MIN -> RUN.
// btnInc bumps the field being set, and the field being set blinks.
// Optional macro CLOCK_TIME_CTRL_12H_EN: shows the hour in 12-hour form with a
// PM flag. Internal time stays 24-hour.
module clock_time_ctrl #(
  parameter int INIT_HOUR = 12,
  parameter int INIT_MIN  = 0
) (
  input  logic              sysclk,
  input  logic              rst_n,
  clock_time_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  localparam logic [3:0] INIT_HT = 4'(INIT_HOUR / 10);
  localparam logic [3:0] INIT_HO = 4'(INIT_HOUR % 10);
  localparam logic [3:0] INIT_MT = 4'(INIT_MIN / 10);
  localparam logic [3:0] INIT_MO = 4'(INIT_MIN % 10);

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [3:0] ht_q, ht_d;
  logic [3:0] ho_q, ho_d;
  logic [3:0] mt_q, mt_d;
  logic [3:0] mo_q, mo_d;
  logic       phase_q, phase_d;
  logic       btn_mode_q;
  logic       btn_inc_q;

  logic       ev_mode;
  logic       ev_inc;

  assign ev_mode = bus.btnMode & ~btn_mode_q;
  assign ev_inc  = bus.btnInc  & ~btn_inc_q;

  // State, time digits, blink phase and button history registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sec_q      <= '0;
      ht_q       <= INIT_HT;
      ho_q       <= INIT_HO;
      mt_q       <= INIT_MT;
      mo_q       <= INIT_MO;
      phase_q    <= 1'b0;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      ht_q       <= ht_d;
      ho_q       <= ho_d;
      mt_q       <= mt_d;
      mo_q       <= mo_d;
      phase_q    <= phase_d;
      btn_mode_q <= bus.btnMode;
      btn_inc_q  <= bus.btnInc;
    end
  end

  // Next state: time advance in RUN, field increments in the SET states.
  // A mode event takes priority over an increment on the same edge.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    ht_d    = ht_q;
    ho_d    = ho_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    phase_d = phase_q;

    case (state_q)
      RUN: begin
        // The tick is applied even when a mode event arrives on the same edge.
        if (bus.tick1s) begin
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (mo_q == 4'd9) begin
              mo_d = 4'd0;
              if (mt_q == 4'd5) begin
                mt_d = 4'd0;
                if (ht_q == 4'd2 && ho_q == 4'd3) begin
                  ht_d = 4'd0;
                  ho_d = 4'd0;
                end else if (ho_q == 4'd9) begin
                  ho_d = 4'd0;
                  ht_d = ht_q + 4'd1;
                end else begin
                  ho_d = ho_q + 4'd1;
                end
              end else begin
                mt_d = mt_q + 4'd1;
              end
            end else begin
              mo_d = mo_q + 4'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (ev_mode) begin
          state_d = SET_HOUR;
          phase_d = 1'b0;
        end
      end

      SET_HOUR: begin
        if (ev_mode) begin
          state_d = SET_MIN;
          phase_d = 1'b0;
        end else if (ev_inc) begin
          phase_d = 1'b0;
          if (ht_q == 4'd2 && ho_q == 4'd3) begin
            ht_d = 4'd0;
            ho_d = 4'd0;
          end else if (ho_q == 4'd9) begin
            ho_d = 4'd0;
            ht_d = ht_q + 4'd1;
          end else begin
            ho_d = ho_q + 4'd1;
          end
        end else if (bus.tick1s) begin
          phase_d = ~phase_q;
        end
      end

      SET_MIN: begin
        if (ev_mode) begin
          state_d = RUN;
          sec_d   = '0;
          phase_d = 1'b0;
        end else if (ev_inc) begin
          // Minute wraps without carrying into the hour.
          phase_d = 1'b0;
          if (mo_q == 4'd9) begin
            mo_d = 4'd0;
            mt_d = (mt_q == 4'd5) ? 4'd0 : mt_q + 4'd1;
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end else if (bus.tick1s) begin
          phase_d = ~phase_q;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  logic blink_hour;
  logic blink_min;

  assign blink_hour = (state_q == SET_HOUR) & phase_q;
  assign blink_min  = (state_q == SET_MIN)  & phase_q;

`ifdef CLOCK_TIME_CTRL_12H_EN
  logic [4:0] hour_bin;
  logic [4:0] disp_bin;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;

  // Map the 24-hour value onto 12-hour display digits and the PM flag.
  always_comb begin
    hour_bin = 5'({1'b0, ht_q} * 5'd10) + {1'b0, ho_q};
    if (hour_bin == 5'd0) begin
      disp_bin = 5'd12;
    end else if (hour_bin > 5'd12) begin
      disp_bin = hour_bin - 5'd12;
    end else begin
      disp_bin = hour_bin;
    end
    if (disp_bin >= 5'd10) begin
      disp_tens = 4'd1;
      disp_ones = 4'(disp_bin - 5'd10);
    end else begin
      disp_tens = 4'd0;
      disp_ones = 4'(disp_bin);
    end
  end

  assign bus.hTens = disp_tens;
  assign bus.hOnes = disp_ones;
  assign bus.pm    = (hour_bin >= 5'd12);
  // A leading zero on the hour is never lit in 12-hour form.
  assign bus.blank = {blink_hour | (disp_tens == 4'd0), blink_hour,
                      blink_min, blink_min};
`else
  assign bus.hTens = ht_q;
  assign bus.hOnes = ho_q;
  assign bus.pm    = 1'b0;
  assign bus.blank = {blink_hour, blink_hour, blink_min, blink_min};
`endif

  assign bus.mTens = mt_q;
  assign bus.mOnes = mo_q;
  assign bus.mode  = state_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl in the default 24-hour build.
module tb_clock_time_ctrl;

  logic sysclk;
  logic rst_n;

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(.INIT_HOUR(12), .INIT_MIN(0)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  // Clock and reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       bm;
    logic       bi;
    logic       tk;
    logic [3:0] ht;
    logic [3:0] ho;
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] bl;
    logic [1:0] md;
  } vec_t;

  vec_t vecs[19];

  // Scoreboard check
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m);
    check({name, ".hTens"}, 8'(bus.hTens), 8'(h / 10));
    check({name, ".hOnes"}, 8'(bus.hOnes), 8'(h % 10));
    check({name, ".mTens"}, 8'(bus.mTens), 8'(m / 10));
    check({name, ".mOnes"}, 8'(bus.mOnes), 8'(m % 10));
  endtask

  // Driver tasks: inputs change 2 ns after a rising edge, outputs sampled there.
  task automatic step(input logic bm, input logic bi, input logic tk);
    bus.btnMode = bm;
    bus.btnInc  = bi;
    bus.tick1s  = tk;
    @(posedge sysclk);
    #2;
  endtask

  task automatic press_mode();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.btnMode = 1'b0;
    bus.btnInc  = 1'b0;
    bus.tick1s  = 1'b0;
    repeat (2) @(posedge sysclk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Cycle-by-cycle vectors starting from reset (12:00, RUN).
    //          bm    bi    tk    ht    ho    mt    mo    blank    mode
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 4'b0000, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd3, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd4, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd4, 4'd0, 4'd0, 4'b1100, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd4, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd4, 4'd0, 4'd0, 4'b1100, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd5, 4'd0, 4'd0, 4'b0000, 2'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 4'd0, 4'b0000, 2'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd5, 4'd0, 4'd0, 4'b0011, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd2};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 4'd1, 4'd5, 4'd0, 4'd1, 4'b0000, 2'd1};

    do_reset();

    // Reset values
    check_time("reset", 12, 0);
    check("reset.blank", 8'(bus.blank), 8'd0);
    check("reset.mode", 8'(bus.mode), 8'd0);
    check("reset.pm", 8'(bus.pm), 8'd0);

    // Table-driven vectors
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].bm, vecs[i].bi, vecs[i].tk);
      check($sformatf("vec%0d.hTens", i), 8'(bus.hTens), 8'(vecs[i].ht));
      check($sformatf("vec%0d.hOnes", i), 8'(bus.hOnes), 8'(vecs[i].ho));
      check($sformatf("vec%0d.mTens", i), 8'(bus.mTens), 8'(vecs[i].mt));
      check($sformatf("vec%0d.mOnes", i), 8'(bus.mOnes), 8'(vecs[i].mo));
      check($sformatf("vec%0d.blank", i), 8'(bus.blank), 8'(vecs[i].bl));
      check($sformatf("vec%0d.mode", i), 8'(bus.mode), 8'(vecs[i].md));
    end

    // Minute wrap in SET_MIN without hour carry, then a long hold
    do_reset();
    press_mode();
    press_inc(3);
    check_time("set_hour15", 15, 0);
    press_mode();
    check("set_min.mode", 8'(bus.mode), 8'd2);
    press_inc(59);
    check_time("set_min59", 15, 59);
    press_inc(1);
    check_time("min_wrap", 15, 0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_time("held_inc", 15, 1);

    // Hour wrap in SET_HOUR and the midnight rollover in RUN
    do_reset();
    press_mode();
    press_inc(11);
    check_time("hour23", 23, 0);
    press_inc(1);
    check_time("hour_wrap", 0, 0);
    press_inc(23);
    check_time("hour23b", 23, 0);
    press_mode();
    press_inc(59);
    check_time("preload", 23, 59);
    press_mode();
    check("preload.mode", 8'(bus.mode), 8'd0);
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (i < 60) check_time($sformatf("tick%0d", i), 23, 59);
      else        check_time("midnight", 0, 0);
      step(1'b0, 1'b0, 1'b0);
    end

    // Blink sequence in SET_HOUR, then asynchronous reset between edges
    do_reset();
    press_mode();
    check("blink0", 8'(bus.blank), 8'b0000);
    step(1'b0, 1'b0, 1'b1);
    check("blink1", 8'(bus.blank), 8'b1100);
    step(1'b0, 1'b0, 1'b1);
    check("blink2", 8'(bus.blank), 8'b0000);
    step(1'b0, 1'b0, 1'b1);
    check("blink3", 8'(bus.blank), 8'b1100);
    press_inc(2);
    check_time("pre_rst", 14, 0);
    step(1'b0, 1'b0, 1'b1);
    check("pre_rst.blank", 8'(bus.blank), 8'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.blank", 8'(bus.blank), 8'b0000);
    check("async.mode", 8'(bus.mode), 8'd0);
    check_time("async", 12, 0);
    @(posedge sysclk);
    #2;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Time-keeping and set-mode controller for the 4-digit 7-segment clock display.
- Holds the running 24-hour time as BCD digits and advances it on the 1 s tick.
- Sequences the user set modes (hour, minute) from two debounced buttons.
- Drives the four digit values and a per-digit blank mask into the display mux in place of fixed test values.

Parameters:
- INIT_HOUR, 12, reset hour, 0..23, binary.
- INIT_MIN, 0, reset minute, 0..59, binary.

Ports:
- sysclk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick1s  in  1  one-sysclk-wide enable pulse, once per second, from clk_1s.
- btnMode  in  1  mode button level; debounced and synchronous to sysclk upstream.
- btnInc  in  1  increment button level; debounced and synchronous to sysclk upstream.
- hTens  out  4  hour tens BCD.
- hOnes  out  4  hour ones BCD.
- mTens  out  4  minute tens BCD.
- mOnes  out  4  minute ones BCD.
- blank  out  4  per-digit blank: [3]=hTens, [2]=hOnes, [1]=mTens, [0]=mOnes; 1 = digit off.
- mode  out  2  current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN.
- pm  out  1  PM indicator; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - State RUN; seconds = 0; blink phase = 0; button history regs = 0.
  - Digits = INIT_HOUR:INIT_MIN in BCD; blank = 0000; mode = 00.
  - pm = 0 without the macro; with the macro, pm = (INIT_HOUR>=12).
- Edge detect:
  - Each button is registered once (btnX_q).
  - evMode = btnMode & ~btnMode_q; evInc = btnInc & ~btnInc_q.
  - An event takes effect on the same rising edge at which it is evaluated.
  - Outputs are registered, so a button going high before edge k is visible after edge k.
  - Holding a button produces exactly one event; a new event requires release then press.
- State machine, advanced on evMode: RUN -> SET_HOUR -> SET_MIN -> RUN.
- SET_MIN -> RUN transition clears seconds to 0 and blink phase to 0.
- RUN:
  - On tick1s, seconds +1.
  - At seconds=59: seconds -> 0 and minute +1.
  - At minute 59: minute -> 00 and hour +1; hour 23 -> 00.
  - 23:59:59 + tick -> 00:00:00.
  - evInc is ignored.
  - blank = 0000.
- SET_HOUR:
  - Time frozen; tick1s does not advance seconds.
  - evInc: hour +1, 23 -> 00; minute unchanged.
- SET_MIN:
  - Time frozen.
  - evInc: minute +1, 59 -> 00; no carry into hour; seconds unchanged.
- Blink phase:
  - Toggles on every tick1s while in either SET state.
  - SET_HOUR: blank = {phase, phase, 0, 0}. SET_MIN: blank = {0, 0, phase, phase}.
  - Entering a SET state forces phase = 0, so digits are visible immediately.
  - Any evInc forces phase = 0 on that edge.
- Simultaneous events: evMode and evInc on the same edge -> mode transition only; evInc is dropped.
- tick1s coincident with evMode in RUN: the tick is applied first (time advances), then the state becomes SET_HOUR.
- Digits are held internally as BCD counters (ones 0..9, tens 0..5 for minutes, 0..2 for hours).
  - Hour wrap checks the full pair {hTens,hOnes} == 2,3.
  - No digit ever leaves its legal BCD range.
- Reset asserted mid-operation returns to the reset values immediately, whatever the state or pending events.

Optional Feature:
- Macro: CLOCK_TIME_CTRL_12H_EN.
- Defined:
  - Internal time stays 24-hour; hTens/hOnes show the 12-hour form.
  - Hour 0 -> 12, 1..12 unchanged, 13..23 -> 1..11.
  - hTens shows 0 for hours 1..9; blank[3] is forced to 1 whenever the displayed hTens = 0.
  - pm = 1 for internal hours 12..23.
  - SET_HOUR increments the internal hour, so the sequence 11 AM -> 12 PM toggles pm.
- Undefined: 24-hour display; pm tied 0; blank[3] driven only by blink.

Test Plan:
- Reset with INIT_HOUR=12, INIT_MIN=0 -> digits 1,2,0,0; blank=0000; mode=00; pm=0 (macro off).
- Preload 23:59 via set mode, return to RUN, apply 60 tick1s pulses -> 00:00 after the 60th tick; the minute never shows 60.
- RUN at 12:00; press btnMode once -> mode=01. Three btnInc presses -> 15:00. Press btnMode -> mode=10. Btn held high 100 cycles -> minute +1 only (15:01).
- SET_MIN at 15:59; btnInc -> 15:00; the hour stays 15.
- Same-cycle btnMode+btnInc rising in SET_HOUR -> mode=10; hour unchanged.
- SET_HOUR; 3 tick1s pulses -> blank[3:2] sequence 11, 00, 11; blank[1:0]=00 throughout. Assert rst_n=0 mid-sequence -> blank=0000, mode=00, digits 1,2,0,0 without waiting for a clock edge.
